// File: rtl/reg_file.sv
// reg_file: 2**LOG_DEPTH x WIDTH register file with two combinational read ports, one write port and write-through bypass.
// Define ZERO_REG_EN to hard-wire register 0 to zero (MIPS $zero).
module reg_file #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 regWrite,
    input  logic [LOG_DEPTH-1:0] writeRegAdd,
    input  logic [WIDTH-1:0]     writeRegData,
    input  logic [LOG_DEPTH-1:0] readRegAdd1,
    input  logic [LOG_DEPTH-1:0] readRegAdd2,
    output logic [WIDTH-1:0]     readRegData1,
    output logic [WIDTH-1:0]     readRegData2
);
    localparam int DEPTH = 2 ** LOG_DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             zero1, zero2;

`ifdef ZERO_REG_EN
    assign wr_en = regWrite && (writeRegAdd != '0);
    assign zero1 = (readRegAdd1 == '0);
    assign zero2 = (readRegAdd2 == '0);
`else
    assign wr_en = regWrite;
    assign zero1 = 1'b0;
    assign zero2 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[writeRegAdd] <= writeRegData;
        end
    end

    // Bypass makes a same-cycle write visible before the edge commits it.
    always_comb begin
        readRegData1 = (!rst || zero1) ? '0 :
                       (wr_en && readRegAdd1 == writeRegAdd) ? writeRegData : mem_q[readRegAdd1];
        readRegData2 = (!rst || zero2) ? '0 :
                       (wr_en && readRegAdd2 == writeRegAdd) ? writeRegData : mem_q[readRegAdd2];
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file; expectations for register 0 follow ZERO_REG_EN.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        regWrite;
    logic [4:0]  writeRegAdd, readRegAdd1, readRegAdd2;
    logic [31:0] writeRegData, readRegData1, readRegData2;
    int          vectors = 0;
    int          miscompares = 0;

`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    reg_file dut (
        .clk(clk), .rst(rst), .regWrite(regWrite),
        .writeRegAdd(writeRegAdd), .writeRegData(writeRegData),
        .readRegAdd1(readRegAdd1), .readRegAdd2(readRegAdd2),
        .readRegData1(readRegData1), .readRegData2(readRegData2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r0(input logic [31:0] v);
        return ZR ? 32'd0 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        regWrite = 1'b1; writeRegAdd = a; writeRegData = d;
        @(posedge clk);
        #1 regWrite = 1'b0;
    endtask

    initial begin
        rst = 1'b0; regWrite = 1'b1; writeRegAdd = 5'd1; writeRegData = 32'd42;
        readRegAdd1 = 5'd1; readRegAdd2 = 5'd31;
        #30;
        chk("rst_rd1_a1", readRegData1, 32'd0);
        chk("rst_rd2_a31", readRegData2, 32'd0);
        readRegAdd1 = 5'd0; #1;
        chk("rst_rd1_a0", readRegData1, 32'd0);
        regWrite = 1'b0; rst = 1'b1; readRegAdd1 = 5'd1; #1;
        chk("rst_write_dropped", readRegData1, 32'd0);

        wr(5'd0, 32'd555);
        readRegAdd1 = 5'd0; #1;
        chk("reg0_write", readRegData1, r0(32'd555));

        wr(5'd1, 32'd111);
        wr(5'd3, 32'd333);
        readRegAdd1 = 5'd0; readRegAdd2 = 5'd1; #1;
        chk("two_port_p1_a0", readRegData1, r0(32'd555));
        chk("two_port_p2_a1", readRegData2, 32'd111);
        readRegAdd1 = 5'd3; readRegAdd2 = 5'd3; #1;
        chk("same_addr_p1", readRegData1, 32'd333);
        chk("same_addr_p2", readRegData2, 32'd333);

        @(negedge clk);
        regWrite = 1'b1; writeRegAdd = 5'd7; writeRegData = 32'd777; readRegAdd1 = 5'd7; readRegAdd2 = 5'd3; #1;
        chk("bypass1_pre", readRegData1, 32'd777);
        chk("bypass1_other_port", readRegData2, 32'd333);
        @(posedge clk); #1 regWrite = 1'b0; #1;
        chk("bypass1_post", readRegData1, 32'd777);

        @(negedge clk);
        regWrite = 1'b1; writeRegAdd = 5'd9; writeRegData = 32'd999; readRegAdd1 = 5'd1; readRegAdd2 = 5'd9; #1;
        chk("bypass2_pre", readRegData2, 32'd999);
        chk("bypass2_p1_indep", readRegData1, 32'd111);
        @(posedge clk); #1 regWrite = 1'b0; #1;
        chk("bypass2_post", readRegData2, 32'd999);

        @(negedge clk);
        regWrite = 1'b0; writeRegAdd = 5'd3; writeRegData = 32'd1234; readRegAdd1 = 5'd3; #1;
        chk("we0_no_bypass", readRegData1, 32'd333);
        @(posedge clk); #1;
        chk("we0_no_write", readRegData1, 32'd333);

        @(negedge clk);
        regWrite = 1'b1; writeRegAdd = 5'd0; writeRegData = 32'hDEAD_BEEF; readRegAdd1 = 5'd0; #1;
        chk("bypass_a0_pre", readRegData1, r0(32'hDEAD_BEEF));
        @(posedge clk); #1 regWrite = 1'b0; #1;
        chk("bypass_a0_post", readRegData1, r0(32'hDEAD_BEEF));

        wr(5'd5, 32'd1);
        wr(5'd5, 32'd2);
        readRegAdd1 = 5'd5; #1;
        chk("last_write_wins", readRegData1, 32'd2);

        @(negedge clk);
        regWrite = 1'b1; writeRegAdd = 5'd3; writeRegData = 32'd77; readRegAdd1 = 5'd3; readRegAdd2 = 5'd5; #2;
        rst = 1'b0; #1;
        chk("async_rst_p1", readRegData1, 32'd0);
        chk("async_rst_p2", readRegData2, 32'd0);
        @(posedge clk); #1 regWrite = 1'b0; rst = 1'b1; #1;
        chk("rst_clear_a3", readRegData1, 32'd0);
        chk("rst_clear_a5", readRegData2, 32'd0);

        for (int i = 0; i < 32; i++) wr(i[4:0], 32'(i) ^ 32'hA5A5_0000);
        for (int i = 0; i < 32; i++) begin
            readRegAdd1 = i[4:0];
            readRegAdd2 = 5'(31 - i);
            #1;
            chk($sformatf("sweep_p1_%0d", i), readRegData1,
                i == 0 ? r0(32'hA5A5_0000) : (32'(i) ^ 32'hA5A5_0000));
            chk($sformatf("sweep_p2_%0d", 31 - i), readRegData2,
                i == 31 ? r0(32'hA5A5_0000) : (32'(31 - i) ^ 32'hA5A5_0000));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the MIPS datapath.
- Two combinational read ports and one synchronous write port.
- Sits between instruction decode (read addresses) and writeback (write address/data/enable).
- Feeds operand values to the ALU and store path.

Parameters:
- WIDTH, default 32: data width of each register (codebase `width).
- LOG_DEPTH, default 5: address width; the file holds 2**LOG_DEPTH registers (codebase `logDepthReg).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- regWrite  input  1  write enable, sampled on rising clk.
- writeRegAdd  input  LOG_DEPTH  write register index.
- writeRegData  input  WIDTH  write data.
- readRegAdd1  input  LOG_DEPTH  read port 1 index.
- readRegAdd2  input  LOG_DEPTH  read port 2 index.
- readRegData1  output  WIDTH  read port 1 data.
- readRegData2  output  WIDTH  read port 2 data.

Behaviour:
- Storage: 2**LOG_DEPTH registers, each WIDTH bits. Every address value is legal; there is no out-of-range case.
- Reset:
  - rst low clears every register to 0 immediately, with no clock needed.
  - While rst is low, writes are ignored and bypass is disabled, so both read outputs are 0.
  - Reset release takes effect without waiting for a clock edge.
- Write:
  - On rising clk with rst high and regWrite=1, mem[writeRegAdd] <= writeRegData.
  - regWrite=0 leaves all registers unchanged.
- Read:
  - Purely combinational; readRegDataN = mem[readRegAddN], with zero-cycle latency after an address change.
- Write-through bypass:
  - Condition: rst high, regWrite=1 and readRegAddN == writeRegAdd.
  - Result: readRegDataN = writeRegData combinationally in the same cycle, before the edge commits it.
  - The two read ports bypass independently.
- Both read ports may address the same register at once and return identical data.
- Back-to-back writes to the same address: the last write wins.
- A write and a read of different addresses in the same cycle do not interact.
- Reset asserted mid-operation: a write pending on the same edge is dropped; contents become all-zero.

Optional Feature:
- Macro: ZERO_REG_EN.
- Defined (MIPS $zero semantics):
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including when a bypass condition would otherwise apply to address 0.
- Undefined: register 0 is an ordinary register, writable and readable like all others, bypass included.

Test Plan:
- Reset: hold rst low 30 ns, reading addresses 0, 1 and 31 -> both outputs 0. Assert rst mid-run after writes -> all reads 0 immediately, asynchronously.
- Register 0 handling:
  - Stimulus: regWrite=1, write 555 to reg 0, then read reg 0 on port 1.
  - Without ZERO_REG_EN -> 555.
  - With ZERO_REG_EN -> 0.
- Two-port read:
  - Write 111 to reg 1 and 333 to reg 3.
  - Read ports (0, 1) -> (555 or 0 per the macro, 111).
  - Read ports (3, 3) -> (333, 333).
- Bypass:
  - Drive writeRegAdd=7, data 777, readRegAdd1=7 in the same cycle -> readRegData1=777 before the edge, still 777 after.
  - Then writeRegAdd=9, data 999, readRegAdd2=9 -> readRegData2=999 immediately.
- Write enable: regWrite=0 with writeRegAdd=3, data 1234 -> reg 3 still reads 333 and no bypass occurs.
- Full sweep: write address ^ 32'hA5A5_0000 to all 32 registers, then read back on both ports -> every value matches, reg 0 per the macro.
